sw_job_scheduler: RTL and testbench
===================================

# sw_job_scheduler

Job scheduler in front of `FPGAWrapper` that queues Smith-Waterman scoring jobs and issues them to the single wrapper one at a time. Each job is a 16-bit scoring-parameter word (match, mismatch, -alpha, -beta). The block inserts a target-sequence load (`set_t`) whenever one is required. It tags each result and hands it out through a valid/ready port, so a host can stream jobs without sequencing the wrapper's busy/valid protocol itself.

## Interface
- `DEPTH`, default 4: job FIFO entries, a power of 2.
- `RES_W`, default `` `V_E_F_Bit ``: result width.
- `ACK_TO`, default 8: maximum cycles from a start/set pulse to `i_busy` rising.

Ports:
- `clk` in, 1 bit: single clock.
- `rst_n` in, 1 bit: reset, **synchronous, active-low**.
- `i_job_valid` in, 1 bit: job push request.
- `i_job_param` in, 16 bits: {match[15:12], mismatch[11:8], minusAlpha[7:4], minusBeta[3:0]}.
- `o_job_ready` out, 1 bit: FIFO not full.
- `i_load_t` in, 1 bit: request a target reload before the next job.
- `o_set_t` out, 1 bit: to wrapper `i_set_t`.
- `o_start_cal` out, 1 bit: to wrapper `i_start_cal`.
- `o_param` out, 16 bits: to wrapper `i_match`/`i_mismatch`/`i_minusAlpha`/`i_minusBeta`.
- `i_busy` in, 1 bit: from wrapper `o_busy`.
- `i_valid` in, 1 bit: from wrapper `o_valid`.
- `i_result` in, `RES_W` bits: from wrapper `o_result`.
- `o_res_valid` out, 1 bit: result available.
- `o_res_data` out, `RES_W` bits: captured score.
- `o_res_tag` out, 4 bits: job tag.
- `i_res_ready` in, 1 bit: result consumer ready.
- `o_err` out, 1 bit: sticky acknowledge-timeout flag.
- `o_idle` out, 1 bit: FSM in IDLE and FIFO empty.

## Operation
- **FIFO:** stores {tag, param}.
  - A push occurs when `i_job_valid && o_job_ready`.
  - The tag counter (4 bits) increments on each push and wraps 15→0.
  - When the FIFO is full, `o_job_ready` = 0 even if a pop happens in the same cycle.
- **t_loaded flag:** cleared by reset. Set when a SETT sequence completes.
- **load_pending flag:** set by `i_load_t`, or whenever `t_loaded` = 0. Cleared on entry to SETT.
- **FSM states:** IDLE, SETT, T_ACK, T_DONE, PARAM, START, ACK, RES, DONE, OUT.
  - IDLE → SETT if `load_pending` (priority over jobs; taken even with an empty FIFO). Otherwise IDLE → PARAM if the FIFO is non-empty, popping the head into `o_param` and the tag register.
  - SETT (1 cycle, `o_set_t` = 1) → T_ACK.
  - T_ACK → T_DONE on `i_busy`.
  - T_DONE → IDLE on `!i_busy`, setting `t_loaded`.
  - PARAM (1 cycle; `o_param` is stable for at least one cycle before start) → START.
  - START (1 cycle, `o_start_cal` = 1) → ACK.
  - ACK → RES on `i_busy`.
  - RES: captures `i_result` on the first `i_valid` → DONE. If `i_valid` and `!i_busy` occur in the same cycle, capture and go to OUT.
  - DONE → OUT on `!i_busy`.
  - OUT: `o_res_valid` = 1. → IDLE on `i_res_ready`.
- **Acknowledge timeout:** in T_ACK or ACK, a counter counts cycles without `i_busy`. On reaching `ACK_TO`:
  - `o_err` ← 1;
  - return to IDLE;
  - the job is dropped (ACK case) or `t_loaded` stays 0 (T_ACK case).
- `o_param` is held from PARAM until the next pop. It is never changed while the wrapper is busy.
- `o_res_data` and `o_res_tag` are held stable while `o_res_valid` = 1. No new job starts until the result is consumed.

## Timing
- All outputs are registered or decoded from the state register.
- **Reset values:**
  - `o_set_t`, `o_start_cal`, `o_res_valid`, `o_err` = 0;
  - `o_param` = 0, `o_res_data` = 0, `o_res_tag` = 0;
  - `o_job_ready` = 1, `o_idle` = 1.
- `rst_n` low mid-job: at the next edge the FIFO is flushed, both flags and the tag counter are cleared, and the FSM goes to IDLE. Wrapper activity in progress is ignored.
- `o_set_t` and `o_start_cal` are exactly one-cycle pulses.
- **Latency, job pushed at edge N:**
  - with `t_loaded` = 1 and the FSM in IDLE: PARAM at N+1, `o_start_cal` at N+2;
  - `o_res_valid` rises one cycle after `i_busy` falls.
- `i_load_t` asserted while a job is running takes effect at the next IDLE.

## Test plan
- After reset, push 0x2132; the wrapper model goes busy 1 cycle after each pulse and returns result 37.
  - Required: `o_set_t` pulse first, then `o_param` = 0x2132, then `o_start_cal` 1 cycle later.
  - Required output: `o_res_valid` with data = 37, tag = 0.
- Push 0x2132 then 0x1121 back-to-back.
  - Required: a single `o_set_t` only; tags 0 and 1; results in order; `o_start_cal` at N+2 for the second job after the first result is consumed.
- Hold `i_res_ready` = 0 and push 6 jobs.
  - Required: `o_job_ready` falls after 1 job running + 4 queued. No push is lost.
  - Releasing `i_res_ready` drains all jobs in tag order.
- Assert `i_load_t` during job 0.
  - Required: an `o_set_t` pulse occurs between the job 0 result and job 1 `o_start_cal`.
- The wrapper model never raises `i_busy`.
  - Required: `o_err` = 1 exactly 8 cycles after `o_start_cal`, and the next queued job still issues.
- Assert `rst_n` = 0 for 1 cycle while in RES with 2 jobs queued.
  - Required: all outputs return to reset values and `o_idle` = 1.
  - A new push afterwards re-triggers `o_set_t`.

Source files
------------

// File: rtl/sw_job_scheduler.sv
// Smith-Waterman job scheduler: queues scoring-parameter words and issues them
// to a single FPGAWrapper one at a time. It inserts a target load (set_t)
// whenever one is needed, tags each job, and returns tagged results through a
// valid/ready port. The design expects DEPTH to be a power of 2, at least 2.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module sw_job_scheduler #(
  parameter int DEPTH  = 4,
  parameter int RES_W  = `V_E_F_Bit,
  parameter int ACK_TO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_job_valid,
  input  logic [15:0]      i_job_param,
  output logic             o_job_ready,
  input  logic             i_load_t,
  output logic             o_set_t,
  output logic             o_start_cal,
  output logic [15:0]      o_param,
  input  logic             i_busy,
  input  logic             i_valid,
  input  logic [RES_W-1:0] i_result,
  output logic             o_res_valid,
  output logic [RES_W-1:0] o_res_data,
  output logic [3:0]       o_res_tag,
  input  logic             i_res_ready,
  output logic             o_err,
  output logic             o_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(ACK_TO + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // ack_cnt is 1 in the first cycle after the pulse, so it reaches ACK_TO-1
  // in the cycle whose edge is ACK_TO cycles after the pulse.
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TO - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SETT   = 4'd1;
  localparam logic [3:0] S_T_ACK  = 4'd2;
  localparam logic [3:0] S_T_DONE = 4'd3;
  localparam logic [3:0] S_PARAM  = 4'd4;
  localparam logic [3:0] S_START  = 4'd5;
  localparam logic [3:0] S_ACK    = 4'd6;
  localparam logic [3:0] S_RES    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_OUT    = 4'd9;

  logic [3:0]       state;
  logic [3:0]       state_nxt;

  logic [19:0]      fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       tag_cnt;

  logic             t_loaded;
  logic             load_pending;
  logic [TW-1:0]    ack_cnt;
  logic             err;

  logic [15:0]      param_q;
  logic [3:0]       tag_q;
  logic [RES_W-1:0] res_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             need_load;
  logic             in_ack_wait;
  logic             ack_timeout;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  // A pop in the same cycle never reopens a full FIFO.
  assign push        = i_job_valid && !full;
  // Missing target data is treated exactly like an explicit reload request.
  assign need_load   = load_pending || !t_loaded;
  assign pop         = (state == S_IDLE) && !need_load && !empty;
  assign in_ack_wait = (state == S_T_ACK) || (state == S_ACK);
  assign ack_timeout = in_ack_wait && !i_busy && (ack_cnt >= TO_LAST);

  // Next-state logic for the wrapper sequencing FSM
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (need_load)   state_nxt = S_SETT;
        else if (!empty) state_nxt = S_PARAM;
      end
      S_SETT:  state_nxt = S_T_ACK;
      S_T_ACK: begin
        if (i_busy)           state_nxt = S_T_DONE;
        else if (ack_timeout) state_nxt = S_IDLE;
      end
      S_T_DONE: begin
        if (!i_busy) state_nxt = S_IDLE;
      end
      S_PARAM: state_nxt = S_START;
      S_START: state_nxt = S_ACK;
      S_ACK: begin
        if (i_busy)           state_nxt = S_RES;
        else if (ack_timeout) state_nxt = S_IDLE;
      end
      S_RES: begin
        // The wrapper may drop busy in the same cycle it presents the result.
        if (i_valid) state_nxt = i_busy ? S_DONE : S_OUT;
      end
      S_DONE: begin
        if (!i_busy) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tag_cnt, i_job_param};
  end

  // FIFO pointers, occupancy and the job tag counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + 4'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state, target-load bookkeeping, acknowledge timer and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      t_loaded     <= 1'b0;
      load_pending <= 1'b0;
      ack_cnt      <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == S_T_DONE) && !i_busy) t_loaded <= 1'b1;

      // A request arriving in the very cycle SETT is entered is kept, so it
      // costs at most one extra load instead of being lost.
      if ((state == S_IDLE) && need_load) load_pending <= 1'b0;
      if (i_load_t)                       load_pending <= 1'b1;

      if (ack_timeout) err <= 1'b1;

      if ((state == S_SETT) || (state == S_START))
        ack_cnt <= TW'(1);
      else if (in_ack_wait && !i_busy && !ack_timeout)
        ack_cnt <= ack_cnt + TW'(1);
    end
  end

  // Issued parameters, job tag and captured score
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      param_q <= 16'd0;
      tag_q   <= 4'd0;
      res_q   <= '0;
    end else begin
      // Only popped in IDLE, so the word never moves under a busy wrapper
      // and the tag never moves while a result is offered.
      if (pop) {tag_q, param_q} <= fifo_mem[rd_ptr];
      if ((state == S_RES) && i_valid) res_q <= i_result;
    end
  end

  assign o_job_ready = !full;
  assign o_set_t     = (state == S_SETT);
  assign o_start_cal = (state == S_START);
  assign o_param     = param_q;
  assign o_res_valid = (state == S_OUT);
  assign o_res_data  = res_q;
  assign o_res_tag   = tag_q;
  assign o_err       = err;
  assign o_idle      = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Bench for sw_job_scheduler: a behavioural wrapper model, a job/result
// scoreboard checked by an independent monitor, directed scenarios and a
// randomized traffic phase.
module tb_sw_job_scheduler;

  localparam int RES_W  = 16;
  localparam int ACK_TO = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_job_valid = 1'b0;
  logic [15:0]      i_job_param = 16'd0;
  logic             o_job_ready;
  logic             i_load_t = 1'b0;
  logic             o_set_t;
  logic             o_start_cal;
  logic [15:0]      o_param;
  logic             i_busy = 1'b0;
  logic             i_valid = 1'b0;
  logic [RES_W-1:0] i_result = '0;
  logic             o_res_valid;
  logic [RES_W-1:0] o_res_data;
  logic [3:0]       o_res_tag;
  logic             i_res_ready = 1'b0;
  logic             o_err;
  logic             o_idle;

  sw_job_scheduler #(.DEPTH(4), .RES_W(RES_W), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_job_valid(i_job_valid), .i_job_param(i_job_param), .o_job_ready(o_job_ready),
    .i_load_t(i_load_t), .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_param(o_param),
    .i_busy(i_busy), .i_valid(i_valid), .i_result(i_result),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_tag(o_res_tag),
    .i_res_ready(i_res_ready), .o_err(o_err), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard: parameters in issue order, and {tag, score} for jobs that
  // must produce a result.
  logic [15:0] issue_q[$];
  logic [19:0] res_q[$];
  logic [3:0]  tb_tag = 4'd0;
  int          last_push_cyc = 0;

  // Wrapper model controls
  int ignore_starts = 0;
  bit slow = 1'b0;
  int ready_mode = 0;   // 0 always ready, 1 stalled, 2 random

  // Monitor statistics
  int n_set = 0, n_start = 0, n_res = 0;
  int last_set_cyc = 0, last_start_cyc = 0, last_res_cyc = 0, err_cyc = 0;
  logic [15:0] last_res_data = '0;
  logic [3:0]  last_res_tag = '0;

  // The wrapper's score: any fixed function of the parameter word works; this
  // one maps 0x2132 to 37.
  function automatic logic [15:0] score_of(input logic [15:0] p);
    return p - 16'h210D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  // Behavioural FPGAWrapper: busy one cycle after a pulse, busy for a few
  // cycles, one valid cycle for calculations, then idle.
  initial begin
    int  phase = 0;
    int  len = 0;
    bit  is_calc = 1'b0;
    logic [15:0] cap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_busy = 1'b0; i_valid = 1'b0; phase = 0;
      end else begin
        case (phase)
          0: begin
            if (o_set_t) begin
              is_calc = 1'b0; phase = 1;
            end else if (o_start_cal) begin
              if (ignore_starts > 0) ignore_starts--;
              else begin is_calc = 1'b1; cap = o_param; phase = 1; end
            end
          end
          1: begin
            i_busy = 1'b1;
            len = slow ? int'($urandom_range(15, 20)) : int'($urandom_range(1, 4));
            phase = 2;
          end
          2: begin
            if (len > 1) len--;
            else if (is_calc) begin
              i_valid = 1'b1; i_result = score_of(cap);
              if ($urandom_range(0, 1) == 1) begin i_busy = 1'b0; phase = 4; end
              else phase = 3;
            end else phase = 3;
          end
          3: begin i_valid = 1'b0; i_busy = 1'b0; phase = 0; end
          default: begin i_valid = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  // Result consumer
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_res_ready = 1'b1;
        1:       i_res_ready = 1'b0;
        default: i_res_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: samples on the falling edge, away from DUT updates
  logic        prev_set = 0, prev_start = 0, prev_busy = 0, prev2_busy = 0;
  logic        prev_rv = 0, prev_hs = 0, prev_err = 0;
  logic [15:0] prev_param = 0;
  logic [RES_W-1:0] prev_data = 0;
  logic [3:0]  prev_tag = 0;
  always @(negedge clk) begin
    logic [15:0] ep;
    logic [19:0] er;
    logic        hs;
    if (!rst_n) begin
      prev_set = 0; prev_start = 0; prev_busy = 0; prev2_busy = 0;
      prev_rv = 0; prev_hs = 0; prev_err = 0; prev_param = 0;
    end else begin
      if (o_set_t) begin
        chk("set_t_single_cycle", prev_set, 0);
        n_set++; last_set_cyc = cyc;
      end
      if (o_start_cal) begin
        chk("start_single_cycle", prev_start, 0);
        n_start++; last_start_cyc = cyc;
        if (issue_q.size() == 0) fail_now("start_without_job");
        else begin
          ep = issue_q.pop_front();
          chk("start_param", o_param, ep);
          chk("param_setup_cycle", prev_param, ep);
        end
      end
      if (i_busy && prev_busy) chk("param_hold_busy", o_param, prev_param);
      if (o_res_valid && !prev_rv)
        chk("res_valid_after_busy_fall", {prev2_busy, prev_busy}, 2'b10);
      if (o_res_valid && prev_rv && !prev_hs) begin
        chk("res_data_hold", o_res_data, prev_data);
        chk("res_tag_hold", o_res_tag, prev_tag);
      end
      hs = o_res_valid && i_res_ready;
      if (hs) begin
        n_res++; last_res_cyc = cyc + 1;
        last_res_data = o_res_data; last_res_tag = o_res_tag;
        if (res_q.size() == 0) fail_now("unexpected_result");
        else begin
          er = res_q.pop_front();
          chk("res_tag", o_res_tag, er[19:16]);
          chk("res_data", o_res_data, er[15:0]);
        end
      end
      if (o_err && !prev_err) err_cyc = cyc;
      prev_set = o_set_t; prev_start = o_start_cal;
      prev2_busy = prev_busy; prev_busy = i_busy;
      prev_rv = o_res_valid; prev_hs = hs; prev_err = o_err;
      prev_param = o_param; prev_data = o_res_data; prev_tag = o_res_tag;
    end
  end

  task automatic push_job(input logic [15:0] p, input bit expect_res);
    int b = 0;
    @(negedge clk);
    while (!o_job_ready && b < 500) begin @(negedge clk); b++; end
    if (b >= 500) fail_now("push_wait_ready");
    else begin
      i_job_valid = 1'b1; i_job_param = p;
      @(posedge clk);
      #1;
      i_job_valid = 1'b0;
      issue_q.push_back(p);
      if (expect_res) res_q.push_back({tb_tag, score_of(p)});
      tb_tag++;
      last_push_cyc = cyc;
    end
  endtask

  task automatic wait_done(input string name);
    int b = 0;
    @(negedge clk);
    while (!(o_idle && res_q.size() == 0 && issue_q.size() == 0) && b < 3000) begin
      @(negedge clk); b++;
    end
    if (b >= 3000) fail_now({name, "_drain"});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_set_t", o_set_t, 0);
    chk("rst_start_cal", o_start_cal, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_param", o_param, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_res_tag", o_res_tag, 0);
    chk("rst_job_ready", o_job_ready, 1);
    chk("rst_idle", o_idle, 1);
    issue_q.delete(); res_q.delete(); tb_tag = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog global time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, bst, br, b, sa, r0;
    ready_mode = 0;
    do_reset(3);

    // Single job after reset: target load first, score 37, tag 0
    bs = n_set;
    push_job(16'h2132, 1'b1);
    wait_done("single");
    chk("single_set_count", n_set - bs, 1);
    chk("single_set_before_start", last_set_cyc < last_start_cyc, 1);
    chk("single_data", last_res_data, 37);
    chk("single_tag", last_res_tag, 0);

    // Back-to-back jobs: one load, ordered tags, restart two cycles after consume
    do_reset(1);
    bs = n_set; br = n_res; bst = n_start;
    push_job(16'h2132, 1'b1);
    push_job(16'h1121, 1'b1);
    b = 0;
    while (n_res < br + 1 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("b2b_first_result");
    r0 = last_res_cyc;
    b = 0;
    while (n_start < bst + 2 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("b2b_second_start");
    chk("b2b_restart_latency", last_start_cyc - r0, 2);
    wait_done("b2b");
    chk("b2b_set_count", n_set - bs, 1);
    chk("b2b_last_tag", last_res_tag, 1);

    // Push into an idle, loaded scheduler: start pulse two edges after push
    push_job(16'h3344, 1'b1);
    wait_done("latency");
    chk("push_to_start_latency", last_start_cyc - last_push_cyc, 2);

    // Result backpressure fills the FIFO behind one running job
    ready_mode = 1;
    br = n_res;
    for (int i = 0; i < 4; i++) push_job(16'h5000 + 16'(i), 1'b1);
    @(negedge clk);
    chk("bp_ready_before_full", o_job_ready, 1);
    push_job(16'h5004, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_ready_full", o_job_ready, 0);
    fork
      push_job(16'h5005, 1'b1);
      begin
        repeat (10) @(negedge clk);
        chk("bp_ready_still_full", o_job_ready, 0);
        ready_mode = 0;
      end
    join
    wait_done("backpressure");
    chk("bp_results", n_res - br, 6);

    // Reload requested while a job runs is inserted before the next start
    bs = n_set; bst = n_start; br = n_res;
    push_job(16'h4455, 1'b1);
    push_job(16'h5566, 1'b1);
    b = 0;
    while (n_start < bst + 1 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("load_first_start");
    i_load_t = 1'b1;
    @(negedge clk);
    i_load_t = 1'b0;
    b = 0;
    while (n_res < br + 1 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("load_first_result");
    r0 = last_res_cyc;
    wait_done("load");
    chk("load_set_count", n_set - bs, 1);
    chk("load_set_after_result", last_set_cyc > r0, 1);
    chk("load_set_before_start", last_set_cyc < last_start_cyc, 1);

    // Wrapper ignores one start: timeout, job dropped, next job still runs
    ignore_starts = 1;
    bst = n_start; br = n_res;
    push_job(16'h6677, 1'b0);
    push_job(16'h7788, 1'b1);
    b = 0;
    while (n_start < bst + 1 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("timeout_start");
    sa = last_start_cyc;
    wait_done("timeout");
    chk("timeout_err", o_err, 1);
    chk("timeout_err_latency", err_cyc - sa, ACK_TO);
    chk("timeout_results", n_res - br, 1);

    // Reset while a result is pending with two jobs queued
    slow = 1'b1;
    bst = n_start;
    push_job(16'h2222, 1'b1);
    push_job(16'h3333, 1'b1);
    push_job(16'h4444, 1'b1);
    b = 0;
    while (n_start < bst + 1 && b < 2000) begin @(negedge clk); b++; end
    if (b >= 2000) fail_now("midreset_start");
    b = 0;
    while (!i_busy && b < 200) begin @(negedge clk); b++; end
    if (b >= 200) fail_now("midreset_busy");
    repeat (3) @(negedge clk);
    do_reset(1);
    slow = 1'b0;
    bs = n_set;
    push_job(16'h2132, 1'b1);
    wait_done("after_reset");
    chk("after_reset_set_count", n_set - bs, 1);
    chk("after_reset_set_first", last_set_cyc < last_start_cyc, 1);
    chk("after_reset_tag", last_res_tag, 0);

    // Randomized traffic with random consumer stalls and reload requests
    ready_mode = 2;
    br = n_res;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); i_load_t = 1'b1;
        @(negedge clk); i_load_t = 1'b0;
      end
      push_job(16'($urandom), 1'b1);
    end
    wait_done("random");
    chk("random_results", n_res - br, 40);
    chk("random_no_err", o_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
